dram_fifo128: RTL and testbench

Synchronous 128-entry FIFO whose storage is WIDTH bit-slices of the team's RAM128X1D distributed-RAM model. It supplies the write-pointer side and the read-pointer side that sit on the RAM's two ports: writes go through port A/D/WE, reads through DPRA/DPO. A registered output stage with an empty-bypass path turns the asynchronous read port into a valid/ready stream. Used as the default shallow buffer between Verilator-simulated Xilinx-style datapaths.

---
 rtl/dram_fifo_pkg.sv | 26 ++
 rtl/dram_fifo128_if.sv | 27 ++
 rtl/RAM128X1D.sv | 25 ++
 rtl/dram_fifo128_store.sv | 36 +++
 rtl/dram_fifo128.sv | 106 ++++++++++
 tb/tb_dram_fifo128.sv | 208 ++++++++++++++++++++
 6 files changed

// File: rtl/dram_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dram_fifo_pkg
//  Description : Shared sizes and LEVEL threshold helpers for dram_fifo128.
//  Revision    : 1.0 - initial release
// ============================================================================
package dram_fifo_pkg;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned PTR_W = 7;
    localparam int unsigned LVL_W = 8;

    function automatic logic lvl_ge(input logic [LVL_W-1:0] lvl, input int unsigned th);
        return 32'(lvl) >= th;
    endfunction

    function automatic logic lvl_le(input logic [LVL_W-1:0] lvl, input int unsigned th);
        return 32'(lvl) <= th;
    endfunction

    function automatic logic lvl_full(input logic [LVL_W-1:0] lvl);
        return 32'(lvl) == DEPTH;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_fifo128_if.sv
`default_nettype none
// ============================================================================
//  Module      : dram_fifo128_if
//  Description : Write-side and read-side valid/ready stream bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dram_fifo128_if #(
    parameter int unsigned WIDTH = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface
`default_nettype wire

// File: rtl/RAM128X1D.sv
`default_nettype none
// ============================================================================
//  Module      : RAM128X1D
//  Description : 128x1 dual-port distributed RAM model, sync write, async read.
//  Revision    : 1.0 - initial release
// ============================================================================
module RAM128X1D (
    output logic       DPO,
    output logic       SPO,
    input  wire  [6:0] A,
    input  wire        D,
    input  wire  [6:0] DPRA,
    input  wire        WCLK,
    input  wire        WE
);
    logic mem_q [128];

    always_ff @(posedge WCLK) begin
        if (WE) mem_q[A] <= D;
    end

    assign DPO = mem_q[DPRA];
    assign SPO = mem_q[A];
endmodule
`default_nettype wire

// File: rtl/dram_fifo128_store.sv
`default_nettype none
// ============================================================================
//  Module      : dram_fifo128_store
//  Description : WIDTH bit-slices of RAM128X1D sharing write and read addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_fifo128_store
    import dram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  wire              clk,
    input  wire              we_i,
    input  wire  [PTR_W-1:0] wr_addr_i,
    input  wire  [PTR_W-1:0] rd_addr_i,
    input  wire  [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] dpo_o
);
    logic [WIDTH-1:0] spo_unused;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_slice
            RAM128X1D u_ram (
                .DPO  (dpo_o[gi]),
                .SPO  (spo_unused[gi]),
                .A    (wr_addr_i),
                .D    (d_i[gi]),
                .DPRA (rd_addr_i),
                .WCLK (clk),
                .WE   (we_i)
            );
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/dram_fifo128.sv
`default_nettype none
// ============================================================================
//  Module      : dram_fifo128
//  Description : 128-entry FIFO on distributed RAM with registered, bypassable head.
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_fifo128
    import dram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned AFULL_TH  = 120,
    parameter int unsigned AEMPTY_TH = 4
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              flush_i,
    dram_fifo128_if.slave    bus,
    output logic [LVL_W-1:0] level_o,
    output logic             afull_o,
    output logic             aempty_o
);
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_cnt_q, ram_cnt_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] m_data_q, m_data_d, dpo;
    logic             m_valid_q, m_valid_d, s_ready_q, s_ready_d;
    logic             afull_q, afull_d, aempty_q, aempty_d;
    logic             push, pop, load, from_ram, bypass, ram_we;

    dram_fifo128_store #(.WIDTH(WIDTH)) u_store (
        .clk       (clk),
        .we_i      (ram_we),
        .wr_addr_i (wr_ptr_q),
        .rd_addr_i (rd_ptr_q),
        .d_i       (bus.s_data),
        .dpo_o     (dpo)
    );

    always_comb begin
        push     = bus.s_valid & s_ready_q;
        pop      = m_valid_q & bus.m_ready;
        load     = !m_valid_q | bus.m_ready;
        from_ram = load & (ram_cnt_q != '0);
        // An empty RAM behind a free head register lets the new word skip the RAM.
        bypass   = load & (ram_cnt_q == '0) & push;
        ram_we   = push & !bypass & !flush_i;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        level_d   = level_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ram_cnt_d = '0;
            level_d   = '0;
            m_valid_d = 1'b0;
        end else begin
            if (ram_we)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (from_ram) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            ram_cnt_d = ram_cnt_q + PTR_W'(ram_we) - PTR_W'(from_ram);
            level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
            if (load) m_valid_d = from_ram | push;
            if (from_ram)    m_data_d = dpo;
            else if (bypass) m_data_d = bus.s_data;
        end

        s_ready_d = !lvl_full(level_d);
        afull_d   = lvl_ge(level_d, AFULL_TH);
        aempty_d  = lvl_le(level_d, AEMPTY_TH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            level_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_ready_q <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            level_q   <= level_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            s_ready_q <= s_ready_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign level_o     = level_q;
    assign afull_o     = afull_q;
    assign aempty_o    = aempty_q;
endmodule
`default_nettype wire

// File: tb/tb_dram_fifo128.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dram_fifo128
//  Description : Directed vector table plus queue-model sequences for dram_fifo128.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_fifo128;

    typedef struct {
        logic       fl;
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic [7:0] lvl;
        logic       mv;
        logic [7:0] md;
        logic       chk_md;
        logic       sr;
        logic       af;
        logic       ae;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [7:0] level;
    logic       afull, aempty;

    int vectors = 0;
    int fails   = 0;

    logic [7:0] q[$];
    logic       exp_sready;
    logic       last_push, last_pop;

    dram_fifo128_if #(.WIDTH(8)) bus ();

    dram_fifo128 #(.WIDTH(8), .AFULL_TH(120), .AEMPTY_TH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .bus      (bus),
        .level_o  (level),
        .afull_o  (afull),
        .aempty_o (aempty)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset(input string name);
        vectors++;
        if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 ||
            level !== 8'd0 || afull !== 1'b0 || aempty !== 1'b1) begin
            fails++;
            $display("FAIL %s: got sr=%b mv=%b md=%h lvl=%0d af=%b ae=%b, want sr=0 mv=0 md=00 lvl=0 af=0 ae=1",
                     name, bus.s_ready, bus.m_valid, bus.m_data, level, afull, aempty);
        end
    endtask

    task automatic check_model(input string name);
        int         n;
        logic       e_mv;
        logic [7:0] e_md;
        n    = q.size();
        e_mv = (n > 0);
        e_md = e_mv ? q[0] : 8'h00;
        vectors++;
        if (level !== 8'(n) || bus.m_valid !== e_mv || (e_mv && bus.m_data !== e_md) ||
            bus.s_ready !== exp_sready || afull !== (n >= 120) || aempty !== (n <= 4)) begin
            fails++;
            $display("FAIL %s: got lvl=%0d mv=%b md=%h sr=%b af=%b ae=%b, want lvl=%0d mv=%b md=%h sr=%b af=%b ae=%b",
                     name, level, bus.m_valid, bus.m_data, bus.s_ready, afull, aempty,
                     n, e_mv, e_md, exp_sready, (n >= 120), (n <= 4));
        end
    endtask

    task automatic cyc(input logic fl, input logic sv, input logic [7:0] sd,
                       input logic mr, input string name);
        flush       = fl;
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        last_push   = sv && exp_sready && !fl;
        last_pop    = (q.size() > 0) && mr && !fl;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (last_pop)  void'(q.pop_front());
            if (last_push) q.push_back(sd);
        end
        exp_sready = (q.size() != 128);
        #1;
        check_model(name);
    endtask

    vec_t tbl[19];

    initial begin
        int         pops, cycles;
        logic [7:0] nxt;
        logic [7:0] got_md;

        tbl[0]  = '{0, 0, 8'h00, 0, 8'd0, 0, 8'h00, 0, 1, 0, 1};
        tbl[1]  = '{0, 1, 8'hA5, 0, 8'd1, 1, 8'hA5, 1, 1, 0, 1};
        tbl[2]  = '{0, 0, 8'h00, 1, 8'd0, 0, 8'h00, 0, 1, 0, 1};
        tbl[3]  = '{0, 1, 8'h11, 0, 8'd1, 1, 8'h11, 1, 1, 0, 1};
        tbl[4]  = '{0, 1, 8'h22, 0, 8'd2, 1, 8'h11, 1, 1, 0, 1};
        tbl[5]  = '{0, 1, 8'h33, 0, 8'd3, 1, 8'h11, 1, 1, 0, 1};
        tbl[6]  = '{0, 1, 8'h44, 0, 8'd4, 1, 8'h11, 1, 1, 0, 1};
        tbl[7]  = '{0, 1, 8'h55, 0, 8'd5, 1, 8'h11, 1, 1, 0, 0};
        tbl[8]  = '{0, 1, 8'h66, 1, 8'd5, 1, 8'h22, 1, 1, 0, 0};
        tbl[9]  = '{0, 0, 8'h00, 1, 8'd4, 1, 8'h33, 1, 1, 0, 1};
        tbl[10] = '{0, 0, 8'h00, 0, 8'd4, 1, 8'h33, 1, 1, 0, 1};
        tbl[11] = '{0, 0, 8'h00, 1, 8'd3, 1, 8'h44, 1, 1, 0, 1};
        tbl[12] = '{0, 0, 8'h00, 1, 8'd2, 1, 8'h55, 1, 1, 0, 1};
        tbl[13] = '{0, 0, 8'h00, 1, 8'd1, 1, 8'h66, 1, 1, 0, 1};
        tbl[14] = '{0, 1, 8'h77, 1, 8'd1, 1, 8'h77, 1, 1, 0, 1};
        tbl[15] = '{0, 0, 8'h00, 1, 8'd0, 0, 8'h00, 0, 1, 0, 1};
        tbl[16] = '{1, 1, 8'h88, 0, 8'd0, 0, 8'h00, 0, 1, 0, 1};
        tbl[17] = '{0, 1, 8'h99, 0, 8'd1, 1, 8'h99, 1, 1, 0, 1};
        tbl[18] = '{1, 0, 8'h00, 1, 8'd0, 0, 8'h00, 0, 1, 0, 1};

        rst_n       = 1'b0;
        flush       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_values");
        #3 rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            flush       = tbl[i].fl;
            bus.s_valid = tbl[i].sv;
            bus.s_data  = tbl[i].sd;
            bus.m_ready = tbl[i].mr;
            @(posedge clk);
            #1;
            vectors++;
            got_md = tbl[i].chk_md ? bus.m_data : tbl[i].md;
            if (level !== tbl[i].lvl || bus.m_valid !== tbl[i].mv || got_md !== tbl[i].md ||
                bus.s_ready !== tbl[i].sr || afull !== tbl[i].af || aempty !== tbl[i].ae) begin
                fails++;
                $display("FAIL table[%0d]: got lvl=%0d mv=%b md=%h sr=%b af=%b ae=%b, want lvl=%0d mv=%b md=%h sr=%b af=%b ae=%b",
                         i, level, bus.m_valid, bus.m_data, bus.s_ready, afull, aempty,
                         tbl[i].lvl, tbl[i].mv, tbl[i].md, tbl[i].sr, tbl[i].af, tbl[i].ae);
            end
        end

        q.delete();
        exp_sready = 1'b1;

        for (int i = 0; i < 128; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0, "fill128");
        cyc(1'b0, 1'b1, 8'd128, 1'b0, "push_when_full");

        nxt = 8'd128;
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 1'b1, nxt, 1'b1, "stream_wrap");
            if (last_push) nxt++;
        end
        repeat (140) cyc(1'b0, 1'b0, 8'h00, 1'b1, "drain1");

        pops   = 0;
        cycles = 0;
        while (pops < 10000 && cycles < 40000) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), "random");
            if (last_pop) pops++;
            cycles++;
        end
        vectors++;
        if (pops < 10000) begin
            fails++;
            $display("FAIL random_budget: got %0d words popped, want 10000", pops);
        end
        repeat (140) cyc(1'b0, 1'b0, 8'h00, 1'b1, "drain2");

        for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1, 8'(i + 60), 1'b0, "fill50");
        cyc(1'b1, 1'b1, 8'hEE, 1'b0, "flush_with_push");
        cyc(1'b0, 1'b1, 8'h3C, 1'b0, "after_flush_push");
        cyc(1'b0, 1'b0, 8'h00, 1'b0, "after_flush_hold");

        for (int i = 0; i < 29; i++) cyc(1'b0, 1'b1, 8'(i + 150), 1'b0, "fill30");
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h5A;
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        q.delete();
        exp_sready  = 1'b0;
        @(posedge clk);
        #1 check_reset("reset_held");
        #2 rst_n = 1'b1;
        cyc(1'b0, 1'b1, 8'hAB, 1'b0, "post_reset_first_edge");
        cyc(1'b0, 1'b1, 8'hCD, 1'b0, "post_reset_push");
        cyc(1'b0, 1'b0, 8'h00, 1'b1, "post_reset_pop");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
